// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and default sizing for the FIR sample feeder
package fir_pkg;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_FEEDER_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} feeder_state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: circular sample buffer with occupancy count and full/empty flags
module fir_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign rdata = mem[rptr];
  // storage array needs no reset; only written entries are ever read
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end
  // pointers wrap naturally at the power-of-two depth; level tracks net push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wr ? wptr + 1'b1 : wptr;
      rptr <= rd ? rptr + 1'b1 : rptr;
      level <= level + LW'(wr) - LW'(rd);
    end
  end
endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers samples and hands them one at a time to the FIR controller (optional watchdog: FIR_FEEDER_WATCHDOG_EN)
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH = FIR_FEEDER_DEPTH,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_W-1:0]       fir_data,
  output logic                    fir_input_valid,
  input  logic                    fir_output_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    wd_err
);
  feeder_state_t state, nxt;
  logic full, empty, pop, wd_hit;
  logic [DATA_W-1:0] head;
  assign s_ready = !rst && !full;
  assign pop = state == IDLE && !empty;
  fir_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(s_valid && s_ready),
    .wdata(s_data),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // completion is only honoured in WAIT; IDLE and ISSUE ignore it
  always_comb begin
    nxt = (state == IDLE) ? (empty ? IDLE : ISSUE) :
          (state == ISSUE) ? WAIT :
          (fir_output_valid || wd_hit) ? IDLE : WAIT;
  end
  // decoded outputs
  always_comb begin
    fir_input_valid = state == ISSUE;
    busy = state != IDLE;
  end
  // the popped sample stays put until the next pop so the FIR sees it stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fir_data <= '0;
    else if (pop) fir_data <= head;
  end
`ifdef FIR_FEEDER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] wd_cnt;
  logic wd_flag;
  assign wd_hit = state == WAIT && !fir_output_valid && wd_cnt == CW'(TIMEOUT_CYC - 1);
  assign wd_err = wd_flag;
  // counts WAIT cycles from zero at each entry; a timeout latches the error until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_flag <= 1'b0;
    end else begin
      wd_cnt <= (state == ISSUE) ? '0 : (state == WAIT) ? wd_cnt + 1'b1 : wd_cnt;
      wd_flag <= wd_flag || wd_hit;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed scenarios checked against a queue-based behavioural model
module tb_fir_sample_feeder;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] fir_data;
  logic fir_input_valid;
  logic fir_output_valid = 1'b0;
  logic busy;
  logic [$clog2(DEPTH):0] level;
  logic wd_err;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] issued[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data = '0;
  bit m_issue = 0, m_wait = 0, m_wd = 0;
  int m_wcnt = 0;
  fir_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .fir_data(fir_data),
    .fir_input_valid(fir_input_valid),
    .fir_output_valid(fir_output_valid),
    .busy(busy),
    .level(level),
    .wd_err(wd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // behavioural model: a queue of accepted samples and a one-at-a-time issue/complete handshake
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_data = '0;
      m_issue = 0;
      m_wait = 0;
      m_wd = 0;
      m_wcnt = 0;
    end else begin
      bit acc;
      acc = s_valid && mq.size() < DEPTH;
      if (m_issue) begin
        m_issue = 0;
        m_wait = 1;
        m_wcnt = 0;
      end else if (m_wait) begin
        if (fir_output_valid) m_wait = 0;
`ifdef FIR_FEEDER_WATCHDOG_EN
        else if (m_wcnt == TO - 1) begin
          m_wait = 0;
          m_wd = 1;
        end
`endif
        else m_wcnt++;
      end else if (mq.size() != 0) begin
        m_data = mq.pop_front();
        m_issue = 1;
      end
      if (acc) mq.push_back(s_data);
    end
  end
  // compare every cycle away from the active edge and log issued samples
  always @(negedge clk) begin
    if (!rst) begin
      chk("s_ready", s_ready, mq.size() < DEPTH);
      chk("level", level, mq.size());
      chk("fir_input_valid", fir_input_valid, m_issue);
      chk("busy", busy, m_issue || m_wait);
      chk("fir_data", fir_data, m_data);
      chk("wd_err", wd_err, m_wd);
      if (fir_input_valid) issued.push_back(fir_data);
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      cyc(1);
      n++;
    end
    chk("push_timeout", n < 100, 1);
    cyc(1);
    s_valid = 1'b0;
  endtask
  task automatic serve();
    int n = 0;
    while (!(busy && !fir_input_valid) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("serve_timeout", n < 100, 1);
    fir_output_valid = 1'b1;
    cyc(1);
    fir_output_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fiv", fir_input_valid, 0);
    chk("rst_fir_data", fir_data, 0);
    chk("rst_wd_err", wd_err, 0);
    cyc(2);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_ready, 1);
    cyc(1);
    // single sample latency and hold
    push(16'h1234);
    chk("s1_level", level, 1);
    chk("s1_fiv_early", fir_input_valid, 0);
    cyc(1);
    chk("s1_fiv", fir_input_valid, 1);
    chk("s1_data", fir_data, 16'h1234);
    chk("s1_busy", busy, 1);
    cyc(1);
    chk("s1_fiv_once", fir_input_valid, 0);
    cyc(4);
    chk("s1_busy_wait", busy, 1);
    chk("s1_data_hold", fir_data, 16'h1234);
    serve();
    chk("s1_done", busy, 0);
    chk("s1_data_after", fir_data, 16'h1234);
    // completion ignored in IDLE and ISSUE
    fir_output_valid = 1'b1;
    cyc(1);
    fir_output_valid = 1'b0;
    chk("s2_idle_busy", busy, 0);
    chk("s2_idle_fiv", fir_input_valid, 0);
    push(16'h00AA);
    cyc(1);
    chk("s2_issue", fir_input_valid, 1);
    fir_output_valid = 1'b1;
    cyc(1);
    fir_output_valid = 1'b0;
    chk("s2_issue_ignored", busy, 1);
    cyc(3);
    chk("s2_still_wait", busy, 1);
    serve();
    chk("s2_issued_n", issued.size(), 2);
    chk("s2_issued0", issued[0], 16'h1234);
    chk("s2_issued1", issued[1], 16'h00AA);
    issued.delete();
    // fill to full with FIR stalled
    push(16'h0100);
    cyc(2);
    for (int i = 1; i <= 8; i++) push(DW'(i));
    chk("s3_level_full", level, 8);
    chk("s3_ready_full", s_ready, 0);
    s_data = 16'd9;
    s_valid = 1'b1;
    cyc(3);
    chk("s3_held", level, 8);
    serve();
    begin
      int n = 0;
      while (!s_ready && n < 20) begin
        cyc(1);
        n++;
      end
      chk("s3_ready_timeout", n < 20, 1);
    end
    cyc(1);
    s_valid = 1'b0;
    chk("s3_ninth_in", level, 8);
    for (int i = 0; i < 9; i++) serve();
    chk("s3_issued_n", issued.size(), 10);
    chk("s3_issued_first", issued[0], 16'h0100);
    for (int i = 1; i < 10 && i < issued.size(); i++) chk("s3_order", issued[i], i);
    issued.delete();
    // simultaneous push/pop at level 4 with pointer wrap
    push(16'd100);
    cyc(2);
    for (int i = 101; i <= 104; i++) push(DW'(i));
    chk("s4_level4", level, 4);
    for (int i = 0; i < 16; i++) begin
      fir_output_valid = 1'b1;
      cyc(1);
      fir_output_valid = 1'b0;
      s_data = DW'(105 + i);
      s_valid = 1'b1;
      cyc(1);
      s_valid = 1'b0;
      chk("s4_level_pp", level, 4);
      cyc(1);
    end
    for (int i = 0; i < 5; i++) serve();
    chk("s4_issued_n", issued.size(), 21);
    for (int i = 0; i < 21 && i < issued.size(); i++) chk("s4_order", issued[i], 100 + i);
    issued.delete();
    // reset mid-operation
    push(16'h0200);
    cyc(2);
    for (int i = 1; i <= 3; i++) push(DW'(16'h0200 + i));
    chk("s5_level3", level, 3);
    chk("s5_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("s5_rst_level", level, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_ready", s_ready, 0);
    chk("s5_rst_fiv", fir_input_valid, 0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("s5_idle", busy, 0);
    chk("s5_empty", level, 0);
    chk("s5_no_issue", issued.size(), 1);
    issued.delete();
    // watchdog behaviour
    push(16'h0300);
    cyc(1);
    chk("s6_issue", fir_input_valid, 1);
    cyc(1);
`ifdef FIR_FEEDER_WATCHDOG_EN
    cyc(15);
    chk("s6_wait15", busy, 1);
    chk("s6_no_err", wd_err, 0);
    cyc(1);
    chk("s6_timeout_idle", busy, 0);
    chk("s6_err", wd_err, 1);
    push(16'h0301);
    cyc(1);
    chk("s6_next_issue", fir_input_valid, 1);
    chk("s6_next_data", fir_data, 16'h0301);
    serve();
    chk("s6_sticky", wd_err, 1);
`else
    cyc(40);
    chk("s6_persist", busy, 1);
    chk("s6_no_err", wd_err, 0);
    serve();
    chk("s6_done", busy, 0);
`endif
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
